// File: rtl/logic_4b_pkg.sv
// Shared definitions for the 4-bit logic-gate checker: op encoding, FSM states
// and the reference function for the expected gate result.
package logic_4b_pkg;

  localparam int LOGIC_W = 4;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [LOGIC_W-1:0] logic_4b_ref(
    input logic [1:0]         op,
    input logic [LOGIC_W-1:0] x,
    input logic [LOGIC_W-1:0] y
  );
    case (op)
      OP_AND:  logic_4b_ref = x & y;
      OP_OR:   logic_4b_ref = x | y;
      OP_XOR:  logic_4b_ref = x ^ y;
      default: logic_4b_ref = ~(x & y);
    endcase
  endfunction

endpackage

// File: rtl/logic_4b_ref_unit.sv
// Combinational expected-result mux for the 4-bit logic gates.
module logic_4b_ref_unit
  import logic_4b_pkg::*;
(
  input  logic [1:0]         op,
  input  logic [LOGIC_W-1:0] x,
  input  logic [LOGIC_W-1:0] y,
  output logic [LOGIC_W-1:0] exp_o
);

  assign exp_o = logic_4b_ref(op, x, y);

endmodule

// File: rtl/logic_4b_checker.sv
// Consumes (x, y, o) tuples from a 4-bit logic unit, recomputes the expected
// result one cycle after acceptance, and tallies saturating check/error counts.
module logic_4b_checker
  import logic_4b_pkg::*;
#(
  parameter int WIDTH = LOGIC_W,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic [WIDTH-1:0]   in_o,
  input  logic               in_last,
  output logic [CNT_W-1:0]   chk_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   fail_idx,
  output logic [3*WIDTH-1:0] fail_data,
  output logic               done,
  output logic               pass
);

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic               p_valid, p_last;
  logic [WIDTH-1:0]   p_x, p_y, p_o;
  logic [WIDTH-1:0]   exp_o;
  logic               fail_seen;
  logic               done_q;
  logic               hs, clear, mismatch;

  assign in_ready = (state == S_RUN);
  assign hs       = in_valid && in_ready;
  assign clear    = start && (state != S_RUN);

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (hs && in_last) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // see pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  logic_4b_ref_unit u_ref (
    .op    (op_q),
    .x     (p_x),
    .y     (p_y),
    .exp_o (exp_o)
  );

  assign mismatch = (p_o != exp_o);

  // Stage 1 captures the accepted tuple; stage 2 compares and updates counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_AND;
      p_valid   <= 1'b0;
      p_last    <= 1'b0;
      p_x       <= '0;
      p_y       <= '0;
      p_o       <= '0;
      chk_cnt   <= '0;
      err_cnt   <= '0;
      fail_idx  <= '0;
      fail_data <= '0;
      fail_seen <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      p_valid <= hs;
      if (hs) begin
        p_x    <= in_x;
        p_y    <= in_y;
        p_o    <= in_o;
        p_last <= in_last;
      end
      if (clear) begin
        op_q      <= op;
        chk_cnt   <= '0;
        err_cnt   <= '0;
        fail_idx  <= '0;
        fail_data <= '0;
        fail_seen <= 1'b0;
        done_q    <= 1'b0;
      end else if (p_valid) begin
        if (!(&chk_cnt)) chk_cnt <= chk_cnt + 1'b1;
        if (mismatch) begin
          if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
          if (!fail_seen) begin
            fail_idx  <= chk_cnt;
            fail_data <= {p_x, p_y, p_o};
            fail_seen <= 1'b1;
          end
        end
        if (p_last) done_q <= 1'b1;
      end
    end
  end

  assign done = done_q;
  assign pass = done_q && (err_cnt == '0);

endmodule

// File: tb/tb_logic_4b_checker.sv
// Scoreboard bench: sessions push expected results, a monitor checks them when done rises.
module tb_logic_4b_checker;
  import logic_4b_pkg::*;

  typedef struct {
    logic [7:0]  chk;
    logic [7:0]  err;
    logic [7:0]  idx;
    logic [11:0] data;
    logic        pass;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = OP_AND;
  logic        in_valid = 1'b0;
  logic [3:0]  in_x = '0, in_y = '0, in_o = '0;
  logic        in_last = 1'b0;

  logic        in_ready, done, pass;
  logic [7:0]  chk_cnt, err_cnt, fail_idx;
  logic [11:0] fail_data;

  logic        in_ready4, done4, pass4;
  logic [3:0]  chk_cnt4, err_cnt4, fail_idx4;
  logic [11:0] fail_data4;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  logic done_d = 1'b0;

  always #5 clk = ~clk;

  logic_4b_checker #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in_valid(in_valid),
    .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_o(in_o), .in_last(in_last),
    .chk_cnt(chk_cnt), .err_cnt(err_cnt), .fail_idx(fail_idx),
    .fail_data(fail_data), .done(done), .pass(pass)
  );

  logic_4b_checker #(.WIDTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .op(op), .in_valid(in_valid),
    .in_ready(in_ready4), .in_x(in_x), .in_y(in_y), .in_o(in_o), .in_last(in_last),
    .chk_cnt(chk_cnt4), .err_cnt(err_cnt4), .fail_idx(fail_idx4),
    .fail_data(fail_data4), .done(done4), .pass(pass4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per completed session.
  always @(negedge clk) begin
    if (done && !done_d) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_done: got done=1 expected no session pending");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sess_chk_cnt",   chk_cnt,   e.chk);
        check("sess_err_cnt",   err_cnt,   e.err);
        check("sess_fail_idx",  fail_idx,  e.idx);
        check("sess_fail_data", fail_data, e.data);
        check("sess_pass",      pass,      e.pass);
      end
    end
    done_d = done;
  end

  task automatic start_session(input logic [1:0] o);
    start = 1'b1;
    op    = o;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] x, input logic [3:0] y, input logic [3:0] o,
                      input logic last, input int gap);
    int n = 0;
    in_valid = 1'b1; in_x = x; in_y = y; in_o = o; in_last = last;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL done_timeout: got done=0 expected 1 within 50 cycles");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset state, tuples ignored in IDLE
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_outputs", {chk_cnt, err_cnt, fail_idx, fail_data, done, pass}, 0);
    rst = 1'b0;
    in_valid = 1'b1; in_x = 4'h3; in_y = 4'h5; in_o = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_chk_cnt", chk_cnt, 0);
    check("idle_in_ready", in_ready, 0);

    // 2. OR, all good
    start_session(OP_OR);
    check("run_in_ready", in_ready, 1);
    sb.push_back('{chk: 8'd4, err: 8'd0, idx: 8'd0, data: 12'h000, pass: 1'b1});
    send(4'h0, 4'h0, 4'h0, 1'b0, 0);
    send(4'h0, 4'h1, 4'h1, 1'b0, 1);
    send(4'h1, 4'h0, 4'h1, 1'b0, 0);
    send(4'h1, 4'h1, 4'h1, 1'b1, 0);
    wait_done();
    check("done_in_ready", in_ready, 0);

    // 3. OR, bad second tuple
    start_session(OP_OR);
    sb.push_back('{chk: 8'd3, err: 8'd1, idx: 8'd1, data: 12'h100, pass: 1'b0});
    send(4'h3, 4'h4, 4'h7, 1'b0, 0);
    send(4'h1, 4'h0, 4'h0, 1'b0, 2);
    send(4'hA, 4'h5, 4'hF, 1'b1, 0);
    wait_done();

    // 4. XOR, bad at idx 0 and 2
    start_session(OP_XOR);
    sb.push_back('{chk: 8'd4, err: 8'd2, idx: 8'd0, data: 12'hCA0, pass: 1'b0});
    send(4'hC, 4'hA, 4'h0, 1'b0, 0);
    send(4'hF, 4'h0, 4'hF, 1'b0, 0);
    send(4'h5, 4'h3, 4'h0, 1'b0, 0);
    send(4'h9, 4'h9, 4'h0, 1'b1, 0);
    wait_done();

    // restart from DONE clears results
    start_session(OP_AND);
    check("restart_counters", {chk_cnt, err_cnt, fail_idx, fail_data}, 0);
    check("restart_done", done, 0);
    check("restart_in_ready", in_ready, 1);

    // 5. AND, 20 good tuples: CNT_W=4 instance saturates at 15
    sb.push_back('{chk: 8'd20, err: 8'd0, idx: 8'd0, data: 12'h000, pass: 1'b1});
    for (int i = 0; i < 20; i++) begin
      logic [3:0] v;
      v = 4'(i);
      send(v, 4'hF, v, (i == 19), 0);
    end
    wait_done();
    check("sat4_chk_cnt", chk_cnt4, 4'd15);
    check("sat4_err_cnt", err_cnt4, 4'd0);
    check("sat4_pass", pass4, 1);

    // NAND, bad last tuple
    start_session(OP_NAND);
    sb.push_back('{chk: 8'd2, err: 8'd1, idx: 8'd1, data: 12'h0AE, pass: 1'b0});
    send(4'hF, 4'hF, 4'h0, 1'b0, 0);
    send(4'h0, 4'hA, 4'hE, 1'b1, 0);
    wait_done();

    // start in RUN is ignored; 6. gaps then rst mid-session
    start_session(OP_OR);
    send(4'h6, 4'h1, 4'h7, 1'b0, 3);
    start_session(OP_AND);
    send(4'h8, 4'h8, 4'h8, 1'b0, 2);
    repeat (2) @(posedge clk);
    #1;
    check("gap_chk_cnt", chk_cnt, 2);
    check("run_start_ignored_err", err_cnt, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_outputs", {chk_cnt, err_cnt, fail_idx, fail_data, done, pass}, 0);

    // start coincident with rst: rst wins
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_start_in_ready", in_ready, 0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
